// File: rtl/dma_pkg.sv
// Shared encodings for the DMA bus: transfer sizes, direction and target FSM states.
package dma_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic DMA_RD = 1'b0;
  localparam logic DMA_WR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/dma_target_if.sv
// DMA bus between an initiator (master) and a memory-side target (slave).
interface dma_target_if;

  logic        en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd_wr;
  logic [1:0]  wr_size;
  logic        ready_in;
  logic        ready_out;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output en, addr, wdata, rd_wr, wr_size, ready_in,
    input  ready_out, rdata, err
  );

  modport slave (
    input  en, addr, wdata, rd_wr, wr_size, ready_in,
    output ready_out, rdata, err
  );

endinterface

// File: rtl/dma_target_mem.sv
// Word array with per-byte write enables and a registered read port.
module dma_target_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // NOTE: the array has no reset; clearing it would need a per-word sweep and contents are undefined after reset by design.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    o_rdata <= r_mem[i_idx];
  end

endmodule

// File: rtl/dma_target.sv
// DMA memory-side responder: fixed wait states, lane steering, optional error checks.
// Define DMA_TARGET_ERR_EN to enable range/size/alignment error detection on err.
module dma_target
  import dma_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input logic         clk,
  input logic         reset,
  dma_target_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e        r_state, w_next;
  logic [3:0]    r_cnt;
  logic [31:0]   r_addr, r_wdata;
  logic          r_wr;
  size_e         r_size;

  logic [31:0]   w_addr, w_wdata;
  logic          w_wr;
  size_e         w_size;
  logic          w_accept, w_enter_resp, w_resp, w_err;
  logic [1:0]    w_lane;
  logic [3:0]    w_be, w_mem_we;
  logic [31:0]   w_lane_wdata, w_mask, w_mem_q;
  logic [AW-1:0] w_idx;

  assign w_accept     = (r_state == ST_IDLE) && bus.en;
  assign w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);
  assign w_resp       = (r_state == ST_RESP);

  // NOTE: sequential state uses <= so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.en) w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd1) w_next = ST_RESP;
      ST_RESP: if (bus.ready_in) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= DMA_RD;
      r_size  <= SZ_BYTE;
    end else if (w_accept) begin
      r_cnt   <= 4'(WAIT_CYCLES);
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
      r_wr    <= bus.rd_wr;
      r_size  <= size_e'(bus.wr_size);
    end else if (r_state == ST_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // In IDLE the live bus describes the transfer, so a zero-wait accept can hit memory on the same edge.
  always_comb begin
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_wr    = r_wr;
    w_size  = r_size;
    if (r_state == ST_IDLE) begin
      w_addr  = bus.addr;
      w_wdata = bus.wdata;
      w_wr    = bus.rd_wr;
      w_size  = size_e'(bus.wr_size);
    end
  end

  always_comb begin
    w_lane       = 2'b00;
    w_be         = 4'hF;
    w_lane_wdata = w_wdata;
    w_mask       = 32'hFFFF_FFFF;
    case (w_size)
      SZ_BYTE: begin
        w_lane       = w_addr[1:0];
        w_be         = 4'b0001 << w_lane;
        w_lane_wdata = {4{w_wdata[7:0]}};
        w_mask       = 32'h0000_00FF;
      end
      SZ_HALF: begin
        w_lane       = {w_addr[1], 1'b0};
        w_be         = 4'b0011 << w_lane;
        w_lane_wdata = {2{w_wdata[15:0]}};
        w_mask       = 32'h0000_FFFF;
      end
      default: ;
    endcase
  end

  assign w_idx = AW'((w_addr - BASE_ADDR) >> 2);

`ifdef DMA_TARGET_ERR_EN
  logic [31:0] w_off;
  assign w_off = w_addr - BASE_ADDR;
  assign w_err = (w_off >= 32'(4 * DEPTH_WORDS))
              || (w_size == SZ_RSVD)
              || ((w_size == SZ_HALF) && w_addr[0])
              || ((w_size == SZ_WORD) && (w_addr[1:0] != 2'b00));
`else
  assign w_err = 1'b0;
`endif

  // Commit happens only on the edge entering RESP; a reset on that edge suppresses it.
  assign w_mem_we = (w_enter_resp && (w_wr == DMA_WR) && !w_err && !reset) ? w_be : 4'b0000;

  dma_target_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_idx   (w_idx),
    .i_wdata (w_lane_wdata),
    .o_rdata (w_mem_q)
  );

  assign bus.ready_out = w_resp;
  assign bus.err       = w_resp && w_err;
  assign bus.rdata     = (w_resp && (w_wr == DMA_RD) && !w_err)
                       ? ((w_mem_q >> {w_lane, 3'b000}) & w_mask) : 32'h0;

endmodule

// File: tb/tb_dma_target.sv
// Self-checking bench for dma_target: table of transfers on a 2-wait target plus
// hand sequences for stalls, resets and a zero-wait target.
module tb_dma_target;
  import dma_pkg::*;

`ifdef DMA_TARGET_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dma_target_if bus2 ();
  dma_target_if bus0 ();

  dma_target #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  dma_target #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q_exp[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] er, input logic ee);
    vec_t v;
    v.wr = wr; v.sz = sz; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic set_req(input bit sel, input logic en, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic rin);
    if (sel) begin
      bus0.en = en; bus0.rd_wr = wr; bus0.wr_size = sz;
      bus0.addr = a; bus0.wdata = wd; bus0.ready_in = rin;
    end else begin
      bus2.en = en; bus2.rd_wr = wr; bus2.wr_size = sz;
      bus2.addr = a; bus2.wdata = wd; bus2.ready_in = rin;
    end
  endtask

  task automatic get_resp(input bit sel, output logic ro, output logic [31:0] rd, output logic e);
    if (sel) begin ro = bus0.ready_out; rd = bus0.rdata; e = bus0.err; end
    else     begin ro = bus2.ready_out; rd = bus2.rdata; e = bus2.err; end
  endtask

  // Issues one transfer, optionally stalls the response for `hold` cycles, then completes it.
  task automatic xfer(input bit sel, input vec_t v, input int hold, input string tag);
    exp_t        e;
    logic        ro, er;
    logic [31:0] rd;
    int          lat = 0;
    int          start = cyc;
    int          wc = sel ? 0 : 2;
    exp_t        pushed;
    pushed.rdata = v.exp_rdata; pushed.err = v.exp_err; pushed.lat = wc + 1;
    q_exp.push_back(pushed);
    set_req(sel, 1'b1, v.wr, v.sz, v.addr, v.wdata, hold == 0);
    do begin
      @(posedge clk); #1;
      lat++;
      get_resp(sel, ro, rd, er);
    end while (!ro && lat < 40);
    e = q_exp.pop_front();
    if (!ro) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: ready_out never rose, required after %0d cycles", tag, e.lat);
      set_req(sel, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      return;
    end
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_rdata"}, rd, e.rdata);
    check({tag, "_err"}, {31'h0, er}, {31'h0, e.err});
    for (int i = 0; i < hold; i++) begin
      set_req(sel, (i % 2) == 0, DMA_WR, SZ_WORD, 32'h10, 32'hFFFF_FFFF, 1'b0);
      @(posedge clk); #1;
      get_resp(sel, ro, rd, er);
      check($sformatf("%s_hold%0d_ready", tag, i), {31'h0, ro}, 32'h1);
      check($sformatf("%s_hold%0d_rdata", tag, i), rd, e.rdata);
    end
    if (hold > 0) set_req(sel, 1'b1, v.wr, v.sz, v.addr, v.wdata, 1'b1);
    @(posedge clk); #1;
    set_req(sel, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    get_resp(sel, ro, rd, er);
    check({tag, "_done"}, {31'h0, ro}, 32'h0);
    if (hold == 0) check({tag, "_cycles"}, 32'(cyc - start), 32'(wc + 2));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic        ro, er;
    logic [31:0] rd;
    logic [31:0] exp_w10;
    int          n;

    set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      get_resp(s[0], ro, rd, er);
      check($sformatf("reset%0d_ready", s), {31'h0, ro}, 32'h0);
      check($sformatf("reset%0d_rdata", s), rd, 32'h0);
      check($sformatf("reset%0d_err", s), {31'h0, er}, 32'h0);
    end
    reset = 1'b0;

    exp_w10 = ERR_EN ? 32'h0000_A500 : 32'h7788_A500;
    tbl.push_back(mk(DMA_WR, SZ_WORD, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0));
    tbl.push_back(mk(DMA_RD, SZ_WORD, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0));
    tbl.push_back(mk(DMA_WR, SZ_WORD, 32'h10, 32'h0, 32'h0, 1'b0));
    tbl.push_back(mk(DMA_WR, SZ_BYTE, 32'h11, 32'h1234_56A5, 32'h0, 1'b0));
    tbl.push_back(mk(DMA_RD, SZ_WORD, 32'h10, 32'h0, 32'h0000_A500, 1'b0));
    tbl.push_back(mk(DMA_RD, SZ_BYTE, 32'h11, 32'h0, 32'h0000_00A5, 1'b0));
    tbl.push_back(mk(DMA_WR, SZ_WORD, 32'h14, 32'h1122_3344, 32'h0, 1'b0));
    tbl.push_back(mk(DMA_WR, SZ_HALF, 32'h16, 32'h5555_CAFE, 32'h0, 1'b0));
    tbl.push_back(mk(DMA_RD, SZ_WORD, 32'h14, 32'h0, 32'hCAFE_3344, 1'b0));
    tbl.push_back(mk(DMA_RD, SZ_HALF, 32'h16, 32'h0, 32'h0000_CAFE, 1'b0));
    tbl.push_back(mk(DMA_RD, SZ_BYTE, 32'h17, 32'h0, 32'h0000_00CA, 1'b0));
    tbl.push_back(mk(DMA_WR, SZ_HALF, 32'h13, 32'h0000_7788, 32'h0, ERR_EN));
    tbl.push_back(mk(DMA_RD, SZ_WORD, 32'h10, 32'h0, exp_w10, 1'b0));
    tbl.push_back(mk(DMA_RD, SZ_HALF, 32'h10, 32'h0, 32'h0000_A500, 1'b0));
    tbl.push_back(mk(DMA_RD, SZ_BYTE, 32'h12, 32'h0, ERR_EN ? 32'h0 : 32'h88, 1'b0));
    tbl.push_back(mk(DMA_RD, SZ_WORD, 32'h11, 32'h0, ERR_EN ? 32'h0 : exp_w10, ERR_EN));
    tbl.push_back(mk(DMA_WR, SZ_WORD, 32'h0, 32'h0BAD_F00D, 32'h0, 1'b0));
    tbl.push_back(mk(DMA_RD, SZ_WORD, 32'h1000, 32'h0, ERR_EN ? 32'h0 : 32'h0BAD_F00D, ERR_EN));
    tbl.push_back(mk(DMA_WR, SZ_WORD, 32'h18, 32'h5555_5555, 32'h0, 1'b0));
    tbl.push_back(mk(DMA_WR, SZ_RSVD, 32'h18, 32'hA1B2_C3D4, 32'h0, ERR_EN));
    tbl.push_back(mk(DMA_RD, SZ_WORD, 32'h18, 32'h0, ERR_EN ? 32'h5555_5555 : 32'hA1B2_C3D4, 1'b0));

    foreach (tbl[i]) xfer(1'b0, tbl[i], 0, $sformatf("v%0d", i));

    // Stalled response with en toggling, then confirm nothing was captured meanwhile.
    xfer(1'b0, mk(DMA_RD, SZ_WORD, 32'h10, 32'h0, exp_w10, 1'b0), 5, "hold");
    xfer(1'b0, mk(DMA_RD, SZ_WORD, 32'h10, 32'h0, exp_w10, 1'b0), 0, "post_hold");

    // Reset while waiting: the pending write must not land.
    xfer(1'b0, mk(DMA_WR, SZ_WORD, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0), 0, "pre20");
    set_req(1'b0, 1'b1, DMA_WR, SZ_WORD, 32'h20, 32'h1234_5678, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    get_resp(1'b0, ro, rd, er);
    check("rst_wait_ready", {31'h0, ro}, 32'h0);
    reset = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    xfer(1'b0, mk(DMA_RD, SZ_WORD, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0), 0, "rd20");

    // Reset while responding: the write is already committed, the response is dropped.
    xfer(1'b0, mk(DMA_WR, SZ_WORD, 32'h24, 32'h0, 32'h0, 1'b0), 0, "pre24");
    set_req(1'b0, 1'b1, DMA_WR, SZ_WORD, 32'h24, 32'h0F0F_0F0F, 1'b0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      get_resp(1'b0, ro, rd, er);
    end while (!ro && n < 20);
    check("rst_resp_reached", {31'h0, ro}, 32'h1);
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    get_resp(1'b0, ro, rd, er);
    check("rst_resp_ready", {31'h0, ro}, 32'h0);
    reset = 1'b0;
    xfer(1'b0, mk(DMA_RD, SZ_WORD, 32'h24, 32'h0, 32'h0F0F_0F0F, 1'b0), 0, "rd24");

    // Zero-wait target, back-to-back transfers.
    xfer(1'b1, mk(DMA_WR, SZ_WORD, 32'h40, 32'h1357_9BDF, 32'h0, 1'b0), 0, "z_wr");
    xfer(1'b1, mk(DMA_RD, SZ_WORD, 32'h40, 32'h0, 32'h1357_9BDF, 1'b0), 0, "z_rdw");
    xfer(1'b1, mk(DMA_RD, SZ_BYTE, 32'h43, 32'h0, 32'h0000_0013, 1'b0), 0, "z_rdb");
    xfer(1'b1, mk(DMA_WR, SZ_HALF, 32'h42, 32'h0000_ABCD, 32'h0, 1'b0), 0, "z_wrh");
    xfer(1'b1, mk(DMA_RD, SZ_WORD, 32'h40, 32'h0, 32'hABCD_9BDF, 1'b0), 0, "z_rdw2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
